// File: rtl/pp_pkg.sv
// Shared types and constants for the packet parser.
// Latency: n/a (package only).
// Backpressure: n/a.
package pp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_CRC,
        ST_DONE
    } state_t;

    // data_sel encodings with a dedicated length rule
    localparam logic [3:0] OP0 = 4'd0;
    localparam logic [3:0] OP1 = 4'd1;

    localparam logic [7:0] CRC_POLY = 8'h07;

    // Byte offsets inside a packet; the CRC byte sits at len + PAYLOAD_OFS
    localparam logic [4:0] HDR0_OFS    = 5'd0;
    localparam logic [4:0] HDR1_OFS    = 5'd1;
    localparam logic [4:0] PAYLOAD_OFS = 5'd2;

    // Payload length (1..16) from header byte 0 = {data_sel, byte_cnt}
    function automatic logic [4:0] calc_len(input logic [7:0] hdr0);
        logic [3:0] sel;
        logic [3:0] cnt;
        logic [4:0] l;
        sel = hdr0[7:4];
        cnt = hdr0[3:0];
        case (sel)
            OP0:     l = {3'b000, cnt[3:2]} + 5'd1;
            OP1:     l = {2'b00, cnt[3:2], 1'b0} + {4'b0000, (cnt[1] | cnt[0])} + 5'd1;
            default: l = {1'b0, cnt} + 5'd1;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/packet_parser_crc.sv
// One CRC-8 step (poly 0x07, MSB-first, no reflection) over a whole byte.
// Latency: combinational.
// Backpressure: none.
module crc8_byte_step
    import pp_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    // Fold the byte in, then shift out eight bits with conditional polynomial XOR
    always_comb begin
        logic [7:0] c;
        c = crc_in ^ data_in;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/packet_parser.sv
// Reads one packet (header, payload, CRC) from byte memory, copies payload out, checks CRC.
// Latency: start to irq = len + 5 cycles; reads issued back-to-back.
// Backpressure: none; start is ignored unless idle.
module packet_parser
    import pp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] addr_in,
    input  logic [13:0] addr_out,
    output logic [13:0] mem_rd_addr,
    input  logic [31:0] mem_rd_data,
    output logic        out_we,
    output logic [13:0] out_addr,
    output logic [7:0]  out_data,
    output logic        busy,
    output logic        irq,
    output logic        crc_err,
    output logic [4:0]  len,
    output logic [7:0]  crc_ext
);

    state_t      state_q, state_d;
    logic [13:0] rd_addr_q, rd_addr_d;
    logic [13:0] wr_addr_q, wr_addr_d;
    logic [4:0]  idx_q, idx_d;         // packet offset of the address currently issued
    logic [1:0]  lane_q, lane_d;       // byte lane of last cycle's read
    logic [7:0]  crc_q, crc_d;
    logic [4:0]  len_q, len_d;
    logic [7:0]  crc_ext_q, crc_ext_d;
    logic        crc_err_q, crc_err_d;

    logic [7:0]  rx_byte;
    logic [7:0]  crc_next;
    logic        issue_more;

    assign rx_byte = mem_rd_data[{lane_q, 3'b000} +: 8];

    crc8_byte_step u_crc (
        .crc_in  (crc_q),
        .data_in (rx_byte),
        .crc_out (crc_next)
    );

    // Next-state, read issue, payload write and CRC bookkeeping
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        idx_d     = idx_q;
        lane_d    = rd_addr_q[1:0];
        crc_d     = crc_q;
        len_d     = len_q;
        crc_ext_d = crc_ext_q;
        crc_err_d = crc_err_q;
        out_we    = 1'b0;
        irq       = 1'b0;

        // Offsets 0 and 1 are issued before the new len is latched; any
        // stale len_q still allows them because len_q + 2 >= 2.
        issue_more = (idx_q < (len_q + PAYLOAD_OFS));

        if ((state_q == ST_HDR || state_q == ST_PAYLOAD) && issue_more) begin
            rd_addr_d = rd_addr_q + 14'd1;
            idx_d     = idx_q + 5'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_HDR;
                    rd_addr_d = addr_in;
                    wr_addr_d = addr_out;
                    idx_d     = 5'd0;
                    crc_d     = 8'h00;
                    crc_err_d = 1'b0;
                end
            end
            ST_HDR: begin
                if (idx_q == HDR0_OFS + 5'd1) begin
                    len_d = calc_len(rx_byte);
                end
                if (idx_q == HDR1_OFS + 5'd1) begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                out_we    = 1'b1;
                crc_d     = crc_next;
                wr_addr_d = wr_addr_q + 14'd1;
                // Last payload byte returns in the cycle the CRC address is issued
                if (idx_q == len_q + PAYLOAD_OFS) begin
                    state_d = ST_CRC;
                end
            end
            ST_CRC: begin
                crc_ext_d = rx_byte;
                crc_err_d = (crc_q != rx_byte);
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                irq     = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rd_addr_q <= 14'd0;
            wr_addr_q <= 14'd0;
            idx_q     <= 5'd0;
            lane_q    <= 2'd0;
            crc_q     <= 8'h00;
            len_q     <= 5'd0;
            crc_ext_q <= 8'h00;
            crc_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            idx_q     <= idx_d;
            lane_q    <= lane_d;
            crc_q     <= crc_d;
            len_q     <= len_d;
            crc_ext_q <= crc_ext_d;
            crc_err_q <= crc_err_d;
        end
    end

    assign mem_rd_addr = rd_addr_q;
    assign out_addr    = wr_addr_q;
    assign out_data    = out_we ? rx_byte : 8'h00;
    assign busy        = (state_q != ST_IDLE);
    assign crc_err     = crc_err_q;
    assign len         = len_q;
    assign crc_ext     = crc_ext_q;

endmodule

// File: tb/tb_packet_parser.sv
// Self-checking bench for packet_parser: per-cycle expectation tables built from a packet model.
// Latency: n/a.
// Backpressure: n/a.
module tb_packet_parser;

    localparam int MAXC = 4096;

    typedef logic [7:0] pl_t [16];

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] addr_in;
    logic [13:0] addr_out;
    logic [13:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic        out_we;
    logic [13:0] out_addr;
    logic [7:0]  out_data;
    logic        busy;
    logic        irq;
    logic        crc_err;
    logic [4:0]  len;
    logic [7:0]  crc_ext;

    always #5 clk = ~clk;

    packet_parser dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .addr_in     (addr_in),
        .addr_out    (addr_out),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_we      (out_we),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .busy        (busy),
        .irq         (irq),
        .crc_err     (crc_err),
        .len         (len),
        .crc_ext     (crc_ext)
    );

    // Packet memory: word containing the issued address, one cycle later
    logic [7:0] mem [0:16383];
    always @(posedge clk) begin
        mem_rd_data <= {mem[{mem_rd_addr[13:2], 2'd3}], mem[{mem_rd_addr[13:2], 2'd2}],
                        mem[{mem_rd_addr[13:2], 2'd1}], mem[{mem_rd_addr[13:2], 2'd0}]};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs per cycle
    bit          exp_busy [MAXC];
    bit          exp_irq  [MAXC];
    bit          exp_we   [MAXC];
    bit          exp_err  [MAXC];
    logic [13:0] exp_rd   [MAXC];
    logic [13:0] exp_oaddr[MAXC];
    logic [7:0]  exp_odata[MAXC];
    logic [7:0]  exp_crc  [MAXC];
    logic [4:0]  exp_len  [MAXC];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Payload length straight from the length table
    function automatic int m_len(input logic [7:0] h);
        int sel;
        int bc;
        sel = int'(h[7:4]);
        bc  = int'(h[3:0]);
        if (sel == 0) return bc / 4 + 1;
        if (sel == 1) return (bc / 4) * 2 + ((bc % 4) != 0 ? 1 : 0) + 1;
        return bc + 1;
    endfunction

    // CRC as remainder of (message * x^8) divided by x^8 + x^2 + x + 1
    function automatic logic [7:0] m_crc(input pl_t pl, input int n);
        int r;
        bit b;
        r = 0;
        for (int i = 0; i < n * 8 + 8; i++) begin
            if (i < n * 8) b = pl[i / 8][7 - (i % 8)];
            else           b = 1'b0;
            r = (r << 1) | int'(b);
            if (r[8]) r = r ^ 32'h107;
        end
        return 8'(r);
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Fill expectation tables for a packet accepted in cycle s
    task automatic schedule(input int s, input int l, input logic [13:0] ai, input logic [13:0] ao,
                            input pl_t pl, input logic [7:0] cb);
        bit e;
        int j;
        e = (cb != m_crc(pl, l));
        for (int c = s + 1; c < MAXC; c++) begin
            j = c - s;
            exp_busy[c] = (j <= l + 5);
            exp_irq[c]  = (j == l + 5);
            exp_we[c]   = (j >= 4 && j < 4 + l);
            if (j >= 4 && j < 4 + l) begin
                exp_oaddr[c] = ao + 14'(j - 4);
                exp_odata[c] = pl[j - 4];
            end
            exp_rd[c] = ai + 14'((j - 1 < l + 2) ? j - 1 : l + 2);
            if (j >= l + 5) begin
                exp_len[c] = 5'(l);
                exp_crc[c] = cb;
                exp_err[c] = e;
            end
        end
    endtask

    // Everything returns to reset values after cycle r
    task automatic clear_after(input int r);
        for (int c = r + 1; c < MAXC; c++) begin
            exp_busy[c] = 1'b0;
            exp_irq[c]  = 1'b0;
            exp_we[c]   = 1'b0;
            exp_err[c]  = 1'b0;
            exp_rd[c]   = 14'd0;
            exp_len[c]  = 5'd0;
            exp_crc[c]  = 8'h00;
        end
    endtask

    // Launch one packet from an idle cycle; returns at the irq cycle (or right after a reset)
    task automatic run_pkt(input logic [13:0] ai, input logic [13:0] ao, input logic [7:0] h0,
                           input pl_t pl, input logic [7:0] cb,
                           input int busy_start, input bit irq_start, input int rst_at);
        int l;
        int s;
        l = m_len(h0);
        mem[ai]         = h0;
        mem[ai + 14'd1] = 8'($urandom);
        for (int k = 0; k < l; k++) mem[ai + 14'(2 + k)] = pl[k];
        mem[ai + 14'(l + 2)] = cb;
        s        = cyc;
        start    = 1'b1;
        addr_in  = ai;
        addr_out = ao;
        schedule(s, l, ai, ao, pl, cb);
        for (int j = 1; j <= l + 5; j++) begin
            tick();
            start    = 1'b0;
            addr_in  = 14'($urandom);
            addr_out = 14'($urandom);
            if (j == busy_start) start = 1'b1;
            if (j == l + 5 && irq_start) start = 1'b1;
            if (j == rst_at) begin
                reset = 1'b1;
                clear_after(cyc);
                tick();
                reset = 1'b0;
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_we", 32'(out_we), 32'd0);
                check("rst_out_addr", 32'(out_addr), 32'd0);
                check("rst_out_data", 32'(out_data), 32'd0);
                check("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
                check("rst_len", 32'(len), 32'd0);
                return;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            start = 1'b0;
        end
    endtask

    // Per-cycle comparison against the expectation tables
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            check("busy", 32'(busy), 32'(exp_busy[cyc]));
            check("irq", 32'(irq), 32'(exp_irq[cyc]));
            check("out_we", 32'(out_we), 32'(exp_we[cyc]));
            check("mem_rd_addr", 32'(mem_rd_addr), 32'(exp_rd[cyc]));
            if (exp_we[cyc]) begin
                check("out_addr", 32'(out_addr), 32'(exp_oaddr[cyc]));
                check("out_data", 32'(out_data), 32'(exp_odata[cyc]));
            end
            if (!exp_busy[cyc] || exp_irq[cyc]) begin
                check("len", 32'(len), 32'(exp_len[cyc]));
                check("crc_ext", 32'(crc_ext), 32'(exp_crc[cyc]));
                check("crc_err", 32'(crc_err), 32'(exp_err[cyc]));
            end
        end
    end

    initial begin
        pl_t        pl;
        logic [7:0] h;
        logic [7:0] cb;
        int         l;
        int         bs;

        reset    = 1'b1;
        start    = 1'b0;
        addr_in  = 14'd0;
        addr_out = 14'd0;
        for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
        for (int c = 0; c < MAXC; c++) begin
            exp_rd[c]    = 14'd0;
            exp_oaddr[c] = 14'd0;
            exp_odata[c] = 8'h00;
            exp_crc[c]   = 8'h00;
            exp_len[c]   = 5'd0;
        end
        for (int k = 0; k < 16; k++) pl[k] = 8'h00;

        // Model pins
        check("m_len_20", 32'(m_len(8'h20)), 32'd1);
        check("m_len_07", 32'(m_len(8'h07)), 32'd2);
        check("m_len_15", 32'(m_len(8'h15)), 32'd4);
        check("m_len_2F", 32'(m_len(8'h2F)), 32'd16);
        pl[0] = 8'h01;
        check("m_crc_01", 32'(m_crc(pl, 1)), 32'h07);
        pl[0] = 8'hFF;
        check("m_crc_FF", 32'(m_crc(pl, 1)), 32'hF3);
        pl[1] = 8'h00;
        check("m_crc_FF00", 32'(m_crc(pl, 2)), 32'hD7);

        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Single-byte packet
        pl[0] = 8'h01;
        run_pkt(14'h0100, 14'h0200, 8'h20, pl, 8'h07, 0, 1'b0, 0);
        check("d1_irq", 32'(irq), 32'd1);
        check("d1_len", 32'(len), 32'd1);
        check("d1_crc_err", 32'(crc_err), 32'd0);
        idle(2);

        // OP0 two-byte payload, good then corrupted CRC (CRC over FF,00 is D7)
        pl[0] = 8'hFF;
        pl[1] = 8'h00;
        run_pkt(14'h0400, 14'h0800, 8'h07, pl, 8'hD7, 0, 1'b0, 0);
        check("d2_len", 32'(len), 32'd2);
        check("d2_crc_err", 32'(crc_err), 32'd0);
        idle(1);
        run_pkt(14'h0400, 14'h0800, 8'h07, pl, 8'hF3, 0, 1'b0, 0);
        check("d3_crc_err", 32'(crc_err), 32'd1);
        check("d3_crc_ext", 32'(crc_ext), 32'hF3);
        idle(1);

        // OP1 length rule, four writes
        for (int k = 0; k < 16; k++) pl[k] = 8'(8'h10 + k);
        run_pkt(14'h1233, 14'h0FFE, 8'h15, pl, m_crc(pl, 4), 0, 1'b0, 0);
        check("d4_irq", 32'(irq), 32'd1);
        check("d4_len", 32'(len), 32'd4);
        idle(1);

        // Maximum length, read and write addresses wrap through 0
        for (int k = 0; k < 16; k++) pl[k] = 8'($urandom);
        run_pkt(14'h3FFE, 14'h3FF8, 8'h2F, pl, m_crc(pl, 16), 0, 1'b0, 0);
        check("d5_irq", 32'(irq), 32'd1);
        check("d5_len", 32'(len), 32'd16);
        idle(1);

        // Starts while busy and in the irq cycle are ignored; start right after irq accepted
        run_pkt(14'h2000, 14'h2100, 8'h13, pl, m_crc(pl, 2), 3, 1'b1, 0);
        idle(1);
        run_pkt(14'h2200, 14'h2300, 8'h1F, pl, m_crc(pl, 8), 5, 1'b1, 0);
        idle(2);

        // Reset in the third payload cycle
        run_pkt(14'h0A00, 14'h0B00, 8'h2F, pl, m_crc(pl, 16), 0, 1'b0, 6);
        idle(3);

        // Randomized packets
        for (int p = 0; p < 40; p++) begin
            h = {4'($urandom_range(0, 3)), 4'($urandom)};
            for (int k = 0; k < 16; k++) pl[k] = 8'($urandom);
            l  = m_len(h);
            cb = m_crc(pl, l);
            if ($urandom_range(0, 3) == 0) cb = cb ^ 8'(1 << $urandom_range(0, 7));
            bs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, l + 4)) : 0;
            run_pkt(14'($urandom), 14'($urandom), h, pl, cb, bs, 1'($urandom_range(0, 1)), 0);
            idle(int'($urandom_range(1, 3)));
        end

        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
